mem_stage_ctrl: RTL

Memory-stage consumer of the EX/M pipeline register: takes the ALU result, store data, destination index and control bits, and performs the load/store against the data memory over a req/ack handshake.
Stalls the upstream pipeline while a memory transaction is outstanding.
Contains the M/WB pipeline register and presents writeback data, destination index and reg-write enable to the WB stage.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/FlipFlop.sv | 20 ++
 rtl/mem_byte_lane.sv | 31 +++
 rtl/mem_stage_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stages: control-bundle bit positions,
// memory-stage state encoding and default datapath widths.
package pipeline_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int REG_IDX_W_DEF = 5;

    // Bit positions inside the EX/M control bundle
    localparam int CTRL_MEM_READ   = 0;
    localparam int CTRL_MEM_WRITE  = 1;
    localparam int CTRL_REG_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_BYTE       = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/FlipFlop.sv
// Single-bit storage cell with write enable and asynchronous active-low
// clear; used bit by bit to build pipeline registers.
module FlipFlop (
    input  logic clk,
    input  logic reset,
    input  logic d,
    input  logic write,
    output logic q
);

    // Capture d when write is high, clear on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 1'b0;
        end else if (write) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_byte_lane.sv
// Byte-lane steering between the core and a 32-bit word memory: store data
// replication, byte enables, and load byte selection with sign extension.
module mem_byte_lane #(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        byte_off,
    input  logic              byte_access,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [3:0]        be
);

    logic [7:0] load_byte;

    // Route the addressed byte in both directions; word accesses pass straight through
    always_comb begin
        load_byte = load_data[{byte_off, 3'b000} +: 8];
        if (byte_access) begin
            be    = 4'b0001 << byte_off;
            wdata = {(DATA_W/8){store_data[7:0]}};
            rdata = {{(DATA_W-8){load_byte[7]}}, load_byte};
        end else begin
            be    = 4'hF;
            wdata = store_data;
            rdata = load_data;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage: issues loads/stores over a req/ack bus, stalls the upstream
// pipeline while a transaction is outstanding, flags misaligned accesses and
// bus timeouts, and holds the M/WB pipeline register feeding writeback.
module mem_stage_ctrl
    import pipeline_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int REG_IDX_W = REG_IDX_W_DEF,
    parameter int CTRL_W    = 6,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    input  logic [DATA_W-1:0]    alu_output_in,
    input  logic [DATA_W-1:0]    data_in,
    input  logic [CTRL_W-1:0]    control_in,
    input  logic [REG_IDX_W-1:0] rgD_index_in,
    input  logic                 flush,
    output logic                 stall_out,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [DATA_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic [3:0]           mem_be,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mem_ack,
    output logic [DATA_W-1:0]    wb_data_out,
    output logic [REG_IDX_W-1:0] rgD_index_out,
    output logic                 reg_write_out,
    output logic                 exc_misaligned,
    output logic                 exc_bus_error
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mem_state_e          state, state_nxt;
    logic [CNT_W-1:0]    timeout_cnt;

    logic                op_read, op_write, op_reg_write, op_mem_to_reg, op_byte;
    logic                op_mem, op_misaligned;
    logic                issue, fault, timeout_hit;

    logic [DATA_W-1:0]   lane_wdata, lane_rdata;
    logic [3:0]          lane_be;

    logic [DATA_W-1:0]   wb_data_nxt;
    logic                reg_write_nxt;
    logic                data_we;

    logic                unused_ctrl;

    assign op_read       = control_in[CTRL_MEM_READ];
    assign op_write      = control_in[CTRL_MEM_WRITE];
    assign op_reg_write  = control_in[CTRL_REG_WRITE];
    assign op_mem_to_reg = control_in[CTRL_MEM_TO_REG];
    assign op_byte       = control_in[CTRL_BYTE];
    assign unused_ctrl   = ^control_in[CTRL_W-1:CTRL_BYTE+1];

    assign op_mem        = op_read | op_write;
    assign op_misaligned = op_mem & ((op_read & op_write) |
                                     (~op_byte & (alu_output_in[1:0] != 2'b00)));

    // Gives up on the transaction in the last allowed wait cycle if no ack arrives
    assign timeout_hit   = (state == WAIT) && !mem_ack &&
                           (timeout_cnt == CNT_W'(TIMEOUT - 1));

    mem_byte_lane #(
        .DATA_W      (DATA_W)
    ) u_byte_lane (
        .byte_off    (alu_output_in[1:0]),
        .byte_access (op_byte),
        .store_data  (data_in),
        .load_data   (mem_rdata),
        .wdata       (lane_wdata),
        .rdata       (lane_rdata),
        .be          (lane_be)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: enter WAIT on a request, leave on ack or timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = WAIT;
            WAIT:    if (mem_ack || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decode the instruction in the stage into issue/fault/stall and the M/WB inputs
    always_comb begin
        issue         = 1'b0;
        fault         = 1'b0;
        stall_out     = 1'b0;
        reg_write_nxt = 1'b0;
        wb_data_nxt   = alu_output_in;
        case (state)
            IDLE: begin
                if (valid_in && !flush) begin
                    if (op_mem) begin
                        fault     = op_misaligned;
                        issue     = !op_misaligned;
                        stall_out = !op_misaligned;
                    end else begin
                        reg_write_nxt = op_reg_write;
                    end
                end
            end
            WAIT: begin
                // A flush arriving here is deliberately ignored: the bus access is already in flight
                stall_out     = !mem_ack && !timeout_hit;
                reg_write_nxt = mem_ack && op_reg_write;
                if (op_mem_to_reg) wb_data_nxt = lane_rdata;
            end
            default: ;
        endcase
        // Writeback value and index only move when the stage advances with something to write
        data_we = !stall_out && ((state == WAIT) || valid_in);
    end

    // Wait-cycle counter, restarted with every new request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_cnt <= '0;
        end else if (issue) begin
            timeout_cnt <= '0;
        end else if (state == WAIT && !mem_ack && !timeout_hit) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

    // Bus request registers: load on issue, hold through WAIT, drop req on completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else if (issue) begin
            mem_req   <= 1'b1;
            mem_we    <= op_write;
            mem_addr  <= {alu_output_in[DATA_W-1:2], 2'b00};
            mem_wdata <= lane_wdata;
            mem_be    <= lane_be;
        end else if (state == WAIT && (mem_ack || timeout_hit)) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
        end
    end

    // Exception pulses; they come from different states so can never coincide
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_misaligned <= 1'b0;
            exc_bus_error  <= 1'b0;
        end else begin
            exc_misaligned <= fault;
            exc_bus_error  <= timeout_hit;
        end
    end

    // M/WB register: value and index follow the stage advance, reg_write loads bubbles every cycle
    for (genvar i = 0; i < DATA_W; i++) begin : g_wb_data
        FlipFlop u_ff (
            .clk   (clk),
            .reset (reset),
            .d     (wb_data_nxt[i]),
            .write (data_we),
            .q     (wb_data_out[i])
        );
    end

    for (genvar i = 0; i < REG_IDX_W; i++) begin : g_wb_idx
        FlipFlop u_ff (
            .clk   (clk),
            .reset (reset),
            .d     (rgD_index_in[i]),
            .write (data_we),
            .q     (rgD_index_out[i])
        );
    end

    FlipFlop u_wb_reg_write (
        .clk   (clk),
        .reset (reset),
        .d     (reg_write_nxt),
        .write (1'b1),
        .q     (reg_write_out)
    );

endmodule
